// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - two-entry fetch/decode queue with RV32I field and immediate decode
module if_id_queue #(
  parameter int ADDRESS_WIDTH = 6,
  localparam int PW = ADDRESS_WIDTH + 2
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic [PW-1:0] in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          pc_en,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pc,
  output logic [31:0]   out_instr,
  output logic [6:0]    out_opcode,
  output logic [4:0]    out_rd,
  output logic [4:0]    out_rs1,
  output logic [4:0]    out_rs2,
  output logic [2:0]    out_funct3,
  output logic [6:0]    out_funct7,
  output logic [31:0]   out_imm,
  output logic [1:0]    count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Entry 0 is always the head; entry 1 is the younger entry when count is 2.
  logic [PW-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0]   instr0_q, instr0_d, instr1_q, instr1_d;
  logic [1:0]    count_q, count_d;
  logic          push, pop;

  assign in_ready  = (count_q < 2'd2);
  assign pc_en     = in_ready & ~flush;
  assign out_valid = (count_q != 2'd0);
  assign count     = count_q;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Next-state for the queue: flush wins, then push/pop with a shift toward the head on pop.
  always_comb begin
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    count_d  = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else if (push && pop) begin
      // Only reachable with count 1: the incoming entry replaces the departing head.
      pc0_d    = in_pc;
      instr0_d = in_instr;
    end else if (push) begin
      if (count_q == 2'd0) begin
        pc0_d    = in_pc;
        instr0_d = in_instr;
      end else begin
        pc1_d    = in_pc;
        instr1_d = in_instr;
      end
      count_d = count_q + 2'd1;
    end else if (pop) begin
      pc0_d    = pc1_q;
      instr0_d = instr1_q;
      pc1_d    = '0;
      instr1_d = NOP;
      count_d  = count_q - 2'd1;
    end
  end

  // Queue registers; reset discards entries immediately and restores NOP storage.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc0_q    <= '0;
      pc1_q    <= '0;
      instr0_q <= NOP;
      instr1_q <= NOP;
      count_q  <= 2'd0;
    end else begin
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      count_q  <= count_d;
    end
  end

  // Head presentation: an empty queue looks like a NOP at pc 0 to decode.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP;
    if (out_valid) begin
      out_pc    = pc0_q;
      out_instr = instr0_q;
    end
  end

  assign out_opcode = out_instr[6:0];
  assign out_rd     = out_instr[11:7];
  assign out_funct3 = out_instr[14:12];
  assign out_rs1    = out_instr[19:15];
  assign out_rs2    = out_instr[24:20];
  assign out_funct7 = out_instr[31:25];

  // Immediate format chosen by opcode; unknown opcodes give zero.
  always_comb begin
    out_imm = 32'd0;
    case (out_opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        out_imm = {{20{out_instr[31]}}, out_instr[31:20]};
      OP_STORE:
        out_imm = {{20{out_instr[31]}}, out_instr[31:25], out_instr[11:7]};
      OP_BRANCH:
        out_imm = {{19{out_instr[31]}}, out_instr[31], out_instr[7],
                   out_instr[30:25], out_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        out_imm = {out_instr[31:12], 12'd0};
      OP_JAL:
        out_imm = {{11{out_instr[31]}}, out_instr[31], out_instr[19:12],
                   out_instr[20], out_instr[30:21], 1'b0};
      default:
        out_imm = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue with directed and random traffic
module tb_if_id_queue;

  localparam int AW = 6;
  localparam int PW = AW + 2;

  logic          clock;
  logic          resetn;
  logic          in_valid;
  logic [PW-1:0] in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          pc_en;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_pc;
  logic [31:0]   out_instr;
  logic [6:0]    out_opcode;
  logic [4:0]    out_rd;
  logic [4:0]    out_rs1;
  logic [4:0]    out_rs2;
  logic [2:0]    out_funct3;
  logic [6:0]    out_funct7;
  logic [31:0]   out_imm;
  logic [1:0]    count;

  if_id_queue #(.ADDRESS_WIDTH(AW)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .pc_en(pc_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [31:0]   instr;
  } entry_t;

  entry_t sb[$];
  int n_checks = 0;
  int n_err    = 0;
  bit done     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference immediate built from the RV32I encoding tables, using signed shifts.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic signed [31:0] s;
    logic [31:0] r;
    s = $signed(ins);
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: r = 32'(s >>> 20);
      7'h23: r = (32'(s >>> 20) & 32'hFFFF_FFE0) | 32'(ins[11:7]);
      7'h63: r = (32'(s >>> 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11)
                 | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      7'h37, 7'h17: r = ins & 32'hFFFF_F000;
      7'h6F: r = (32'(s >>> 11) & 32'hFFF0_0000) | (ins & 32'h000F_F000)
                 | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Monitor: compares DUT head and status against the scoreboard, pops on consumption.
  initial begin
    entry_t e;
    bit will_pop;
    while (!done) begin
      @(negedge clock);
      #2;
      if (done) break;
      check("count", 32'(count), 32'(sb.size()));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      check("pc_en", 32'(pc_en), 32'((sb.size() < 2) && !flush));
      if (sb.size() != 0) e = sb[0];
      else begin
        e.pc = '0;
        e.instr = 32'h0000_0013;
      end
      check("out_pc", 32'(out_pc), 32'(e.pc));
      check("out_instr", out_instr, e.instr);
      check("out_opcode", 32'(out_opcode), 32'(e.instr[6:0]));
      check("out_rd", 32'(out_rd), 32'(e.instr[11:7]));
      check("out_funct3", 32'(out_funct3), 32'(e.instr[14:12]));
      check("out_rs1", 32'(out_rs1), 32'(e.instr[19:15]));
      check("out_rs2", 32'(out_rs2), 32'(e.instr[24:20]));
      check("out_funct7", 32'(out_funct7), 32'(e.instr[31:25]));
      check("out_imm", out_imm, ref_imm(e.instr));
      will_pop = resetn && (sb.size() != 0) && out_ready && !flush;
      @(posedge clock);
      if (will_pop && sb.size() != 0) void'(sb.pop_front());
    end
  end

  // One stimulus cycle: drive at negedge, update expected contents at the following edge.
  task automatic cycle(input bit iv, input logic [PW-1:0] pc, input logic [31:0] ins,
                       input bit ordy, input bit fl);
    bit do_push;
    entry_t e;
    @(negedge clock);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    do_push   = iv && (sb.size() < 2) && !fl;
    e.pc      = pc;
    e.instr   = ins;
    @(posedge clock);
    if (fl) sb.delete();
    else if (do_push) sb.push_back(e);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73};
    logic [31:0] r;
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pc_en", 32'(pc_en), 32'd1);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    @(negedge clock);
    resetn = 1'b1;

    // Single push of addi x1,x0,6
    cycle(1, 8'h00, 32'h0060_0093, 0, 0);
    #1;
    check("t33_count", 32'(count), 32'd1);
    check("t33_imm", out_imm, 32'h0000_0006);
    check("t33_rd", 32'(out_rd), 32'd1);
    cycle(0, 8'h00, 32'h0, 1, 0);

    // Branch with negative offset
    cycle(1, 8'h14, 32'hFE00_9CE3, 0, 0);
    #1;
    check("t34_opcode", 32'(out_opcode), 32'h63);
    check("t34_funct3", 32'(out_funct3), 32'd1);
    check("t34_imm", out_imm, 32'hFFFF_FFF8);
    cycle(0, 8'h00, 32'h0, 1, 0);

    // Fill to two, third offered entry must be refused, then drain in order
    cycle(1, 8'h00, 32'h0010_0113, 0, 0);
    cycle(1, 8'h04, 32'h0020_0193, 0, 0);
    #1;
    check("t35_count", 32'(count), 32'd2);
    check("t35_in_ready", 32'(in_ready), 32'd0);
    check("t35_pc_en", 32'(pc_en), 32'd0);
    cycle(1, 8'h08, 32'h0030_0213, 0, 0);
    cycle(0, 8'h00, 32'h0, 1, 0);
    #1;
    check("t35_head2", 32'(out_pc), 32'h04);
    cycle(0, 8'h00, 32'h0, 1, 0);

    // Simultaneous push and pop at count 1
    cycle(1, 8'h1C, 32'h0000_0537, 0, 0);
    cycle(1, 8'h20, 32'h0080_006F, 1, 0);
    #1;
    check("t36_count", 32'(count), 32'd1);
    check("t36_pc", 32'(out_pc), 32'h20);

    // Flush overrides push and pop
    cycle(1, 8'h24, 32'h0041_2023, 0, 0);
    cycle(1, 8'h28, 32'h0000_0013, 1, 1);
    #1;
    check("t37_count", 32'(count), 32'd0);
    check("t37_valid", 32'(out_valid), 32'd0);
    check("t37_instr", out_instr, 32'h0000_0013);

    // Asynchronous reset between edges with two entries queued
    cycle(1, 8'h30, 32'h0000_0297, 0, 0);
    cycle(1, 8'h34, 32'hFFF0_0093, 0, 0);
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #3 resetn = 1'b0;
    #1;
    check("t38_count", 32'(count), 32'd0);
    check("t38_valid", 32'(out_valid), 32'd0);
    check("t38_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    resetn = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [PW-1:0] pc;
      pc = PW'($urandom_range(0, 63) * 4);
      cycle($urandom_range(0, 9) < 7, pc, rand_instr(),
            $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0);
    end
    cycle(0, 8'h00, 32'h0, 0, 0);

    done = 1;
    @(negedge clock);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 6, word-address width of instruction memory; PC width PW = ADDRESS_WIDTH+2.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  fetch stage presents a valid instruction this cycle.
REQ-005 SHALL have port in_pc  input  PW  byte PC of presented instruction.
REQ-006 SHALL have port in_instr  input  32  instruction word read from instruction memory.
REQ-007 SHALL have port in_ready  output  1  queue can accept an entry this cycle.
REQ-008 SHALL have port pc_en  output  1  advance-enable for the program counter.
REQ-009 SHALL have port flush  input  1  branch/jump redirect; discard all queued entries.
REQ-010 SHALL have port out_valid  output  1  head entry valid for decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-012 SHALL have port out_pc  output  PW  PC of head entry.
REQ-013 SHALL have port out_instr  output  32  head instruction word.
REQ-014 SHALL have ports out_opcode 7, out_rd 5, out_rs1 5, out_rs2 5, out_funct3 3, out_funct7 7, all outputs holding the RV32I fields of out_instr.
REQ-015 SHALL have port out_imm  output  32  sign-extended immediate of out_instr.
REQ-016 SHALL have port count  output  2  number of queued entries (0..2).

Function
REQ-017 SHALL be a 2-entry FIFO; head is the oldest entry.
REQ-018 SHALL drive in_ready = (count < 2), independent of out_ready (no pass-through when full).
REQ-019 SHALL drive pc_en = in_ready & ~flush.
REQ-020 SHALL push on rising edge when in_valid & in_ready & ~flush.
REQ-021 SHALL pop on rising edge when out_valid & out_ready & ~flush.
REQ-022 SHALL drive out_valid = (count != 0); latency from push to out_valid is exactly 1 cycle.
REQ-023 On simultaneous push and pop with count=1: count stays 1, pushed entry becomes head next cycle.
REQ-024 On simultaneous push and pop with count=0: pop ignored, push taken, count becomes 1.
REQ-025 flush SHALL set count to 0 on the next edge and SHALL override any push or pop in the same cycle.
REQ-026 When out_valid=0, out_instr SHALL be 32'h00000013 (NOP), out_pc 0, and all decoded fields those of NOP.
REQ-027 Decoded fields SHALL be combinational from the head entry: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
REQ-028 out_imm SHALL select format by opcode: I for 0010011/0000011/1100111; S for 0100011; B for 1100011; U for 0110111/0010111; J for 1101111; else 0.
REQ-029 I/S/B/J immediates SHALL sign-extend instr[31]; B and J SHALL have bit 0 = 0; U SHALL be {instr[31:12],12'b0}.
REQ-030 Queue storage SHALL not change on a cycle with no push, pop, or flush.

Reset
REQ-031 While resetn=0: count=0, out_valid=0, in_ready=1, pc_en=1 (unless flush), storage cleared to pc 0 / instr NOP.
REQ-032 Reset assertion mid-operation SHALL discard all entries immediately, asynchronously to clock.

Verification
REQ-033 Push pc=0x00 instr 0x00600093, out_ready=0 -> next cycle out_valid=1, count=1, opcode=0010011, rd=1, rs1=0, funct3=0, out_imm=0x00000006.
REQ-034 Push pc=0x14 instr 0xFE009CE3 -> out_opcode=1100011, funct3=001, rs1=1, rs2=0, out_imm=0xFFFFFFF8.
REQ-035 Push 3 consecutive entries with out_ready=0 -> count=2 after 2nd, in_ready=0 and pc_en=0, 3rd not stored; then out_ready=1 -> heads pop in order pc 0x00, 0x04.
REQ-036 count=1, in_valid=1, out_ready=1 same cycle -> count stays 1, new pc at head next cycle.
REQ-037 count=2, flush=1 with in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, out_instr=0x00000013.
REQ-038 count=2, resetn pulsed low between edges -> count=0, out_valid=0 immediately, in_ready=1.
